mkio_rt_ctrl: RTL and testbench
===============================

# mkio_rt_ctrl

Remote-terminal command sequencer for the MKIO (GOST 26765.52) interface. Takes decoded words from the Manchester receiver, validates and decodes each command word, and starts the addressed subaddress device (device1..deviceN) for data-word messages. It owns the single transmit path to the encoder, routing the active device's response or its own status word to it. It also times out devices that never respond and counts rejected commands.

## Interface
Parameters:
- RT_ADDRESS, 5'd1, address of this remote terminal
- NUM_DEV, 4, number of attached subaddress devices (1..30); device k serves subaddress k+1
- RESP_TIMEOUT, 8'd200, clk cycles allowed for a started device to raise busy

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- rx_data  in  16  received word
- rx_cd  in  1  1: command/status sync, 0: data sync
- rx_valid  in  1  one-cycle pulse, rx_data/rx_cd/p_error valid
- p_error  in  1  parity error on current word
- tx_busy  in  1  encoder transmitting
- dev_busy  in  NUM_DEV  per-device busy
- dev_tx_data  in  16*NUM_DEV  per-device tx word, device k at [16k+15:16k]
- dev_tx_cd  in  NUM_DEV  per-device word type
- dev_tx_ready  in  NUM_DEV  per-device send request
- dev_start  out  NUM_DEV  one-hot one-cycle start pulse
- cmd_word  out  16  last accepted command word
- tx_data  out  16  word to encoder
- tx_cd  out  1  0: status word, 1: data word
- tx_ready  out  1  send request to encoder
- busy  out  1  message in progress
- err_timeout  out  1  one-cycle pulse on device timeout
- err_count  out  8  rejected-command counter, saturating

## Operation
- Reset (reset=0): state IDLE; all outputs 0; sel=0; timer=0; err_count=0.
- IDLE: on rx_valid&rx_cd, latch rx_data into cmd_word and p_error into pe_q, set busy=1, go to DECODE. Data words (rx_cd=0) are ignored.
- DECODE, with addr=cmd_word[15:11] and sa=cmd_word[9:5]:
  - pe_q=1: err_count+1 (hold at 255), go to DONE, no response.
  - addr≠RT_ADDRESS and addr≠31: go to DONE silently; err_count unchanged.
  - sa=0 or sa=31 (mode code): msg_err=0, go to OWN_RESP.
  - 1≤sa≤NUM_DEV: sel=sa-1, go to DISPATCH.
  - Any other sa: msg_err=1, err_count+1, go to OWN_RESP.
  - bcast=(addr==31) is latched here.
- DISPATCH: dev_start[sel]=1 for exactly one cycle; timer=0; seen=0; go to RUN.
- RUN: route device sel to the tx outputs through a registered mux.
  - tx_ready is forced to 0 when bcast=1.
  - dev_tx_ready of non-selected devices is ignored.
  - dev_busy[sel]=1 sets seen.
  - seen=1 and dev_busy[sel]=0: go to DONE.
  - seen=0 and timer==RESP_TIMEOUT-1: pulse err_timeout, go to DONE.
- OWN_RESP: wait for tx_busy=0, then one cycle with tx_data={RT_ADDRESS,msg_err,10'd0}, tx_cd=0, tx_ready=1 (tx_ready suppressed if bcast). Go to DONE.
- DONE: busy=0, tx_ready=0, go to IDLE.
- Superseding command: rx_valid&rx_cd in DECODE/DISPATCH/RUN/OWN_RESP relatches cmd_word and pe_q and goes to DECODE. The previous device is not stopped; its outputs are no longer routed.
- Start pulses only target sel, so simultaneous device tx_ready requests cannot conflict.

## Timing
- Edge E0 samples rx_valid. cmd_word is valid after E0. dev_start is high between E1 and E2.
- Own status word: tx_ready rises after E2 when tx_busy=0. Each cycle of tx_busy=1 adds one cycle.
- Mux latency: dev_tx_* to tx_* is 1 cycle.
- Timeout: err_timeout pulses RESP_TIMEOUT cycles after the dev_start cycle.
- busy is high from after E0 until after the DONE edge.

## Structure
- Shared package mkio_pkg:
  - state encoding (IDLE, DECODE, DISPATCH, RUN, OWN_RESP, DONE)
  - BROADCAST_ADDR=5'd31 and mode-code subaddresses 0/31
  - command-word field positions (addr 15:11, T/R 10, sa 9:5, count 4:0)
  - status-word bit MSG_ERR=10
- Sub-module mkio_tx_mux: registered NUM_DEV:1 selector of {data,cd,ready} with enable and broadcast mask.

## Test plan
- Cmd 16'h0824 (addr 1, sa 1), no parity error: dev_start=4'b0001 one cycle at E1. Device busy 5 cycles with dev_tx_data=16'h1234 ready: tx_data=16'h1234 one cycle later, then DONE, busy=0.
- Cmd addr 1, sa 7 (NUM_DEV=4): tx_data=16'h0C00, tx_cd=0, one tx_ready pulse, err_count=1.
- Cmd with p_error=1: no dev_start, no tx_ready, err_count increments; 300 such commands leave err_count at 255.
- Cmd addr 31, sa 2: dev_start[1] pulses; tx_ready stays 0 throughout.
- Cmd addr 1, sa 3, dev_busy never rises: err_timeout pulses exactly 200 cycles after dev_start, state returns to IDLE.
- Cmd addr 2 ignored; then cmd sa 1 during RUN of sa 2: dev_start[0] pulses, and device 1's tx_ready is no longer forwarded.
- Assert reset mid-RUN: all outputs 0 immediately.

Source files
------------

// File: rtl/mkio_pkg.sv
// rtl/mkio_pkg.sv - shared MKIO state encoding, field positions and word helpers
package mkio_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECODE,
    ST_DISPATCH,
    ST_RUN,
    ST_OWN_RESP,
    ST_DONE
  } state_t;

  localparam logic [4:0] BROADCAST_ADDR = 5'd31;
  localparam logic [4:0] MODE_SA_LO     = 5'd0;
  localparam logic [4:0] MODE_SA_HI     = 5'd31;

  localparam int ADDR_MSB = 15;
  localparam int ADDR_LSB = 11;
  localparam int TR_BIT   = 10;
  localparam int SA_MSB   = 9;
  localparam int SA_LSB   = 5;
  localparam int CNT_MSB  = 4;
  localparam int CNT_LSB  = 0;

  localparam int MSG_ERR  = 10;

  function automatic logic [4:0] cmd_addr(input logic [15:0] w);
    return w[ADDR_MSB:ADDR_LSB];
  endfunction

  function automatic logic [4:0] cmd_sa(input logic [15:0] w);
    return w[SA_MSB:SA_LSB];
  endfunction

  function automatic logic [15:0] status_word(input logic [4:0] addr, input logic msg_err);
    logic [15:0] s;
    s               = '0;
    s[15:11]        = addr;
    s[MSG_ERR]      = msg_err;
    return s;
  endfunction

endpackage

// File: rtl/mkio_tx_mux.sv
// rtl/mkio_tx_mux.sv - registered NUM_DEV:1 selector of device tx words
// Outputs clear whenever en is low so they can be OR-merged with other sources.
module mkio_tx_mux #(
  parameter int NUM_DEV = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic                   bcast,
  input  logic [4:0]             sel,
  input  logic [16*NUM_DEV-1:0]  dev_tx_data,
  input  logic [NUM_DEV-1:0]     dev_tx_cd,
  input  logic [NUM_DEV-1:0]     dev_tx_ready,
  output logic [15:0]            tx_data,
  output logic                   tx_cd,
  output logic                   tx_ready
);

  logic [15:0] pick_data;
  logic        pick_cd;
  logic        pick_ready;

  always_comb begin
    pick_data  = '0;
    pick_cd    = 1'b0;
    pick_ready = 1'b0;
    for (int k = 0; k < NUM_DEV; k++) begin
      if (sel == 5'(k)) begin
        pick_data  = dev_tx_data[16*k +: 16];
        pick_cd    = dev_tx_cd[k];
        pick_ready = dev_tx_ready[k];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_data  <= '0;
      tx_cd    <= 1'b0;
      tx_ready <= 1'b0;
    end else if (en) begin
      tx_data  <= pick_data;
      tx_cd    <= pick_cd;
      tx_ready <= pick_ready & ~bcast;
    end else begin
      tx_data  <= '0;
      tx_cd    <= 1'b0;
      tx_ready <= 1'b0;
    end
  end

endmodule

// File: rtl/mkio_rt_ctrl.sv
// rtl/mkio_rt_ctrl.sv - MKIO remote-terminal command sequencer
// Decodes command words, starts subaddress devices and owns the encoder tx path.
module mkio_rt_ctrl
  import mkio_pkg::*;
#(
  parameter logic [4:0] RT_ADDRESS   = 5'd1,
  parameter int         NUM_DEV      = 4,
  parameter logic [7:0] RESP_TIMEOUT = 8'd200
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [15:0]            rx_data,
  input  logic                   rx_cd,
  input  logic                   rx_valid,
  input  logic                   p_error,
  input  logic                   tx_busy,
  input  logic [NUM_DEV-1:0]     dev_busy,
  input  logic [16*NUM_DEV-1:0]  dev_tx_data,
  input  logic [NUM_DEV-1:0]     dev_tx_cd,
  input  logic [NUM_DEV-1:0]     dev_tx_ready,
  output logic [NUM_DEV-1:0]     dev_start,
  output logic [15:0]            cmd_word,
  output logic [15:0]            tx_data,
  output logic                   tx_cd,
  output logic                   tx_ready,
  output logic                   busy,
  output logic                   err_timeout,
  output logic [7:0]             err_count
);

  state_t              state;
  logic                pe_q;
  logic                bcast;
  logic                msg_err;
  logic                seen;
  logic [4:0]          sel;
  logic [7:0]          timer;
  logic [15:0]         own_data;
  logic                own_ready;
  logic [15:0]         mux_data;
  logic                mux_cd;
  logic                mux_ready;

  logic [4:0]          addr;
  logic [4:0]          sa;
  logic                new_cmd;
  logic                busy_sel;
  logic                timed_out;
  logic                run_exit;
  logic                mux_en;
  logic [NUM_DEV-1:0]  start_vec;
  logic [7:0]          err_next;

  assign addr      = cmd_addr(cmd_word);
  assign sa        = cmd_sa(cmd_word);
  assign new_cmd   = rx_valid & rx_cd;
  assign timed_out = ~seen & (timer == RESP_TIMEOUT - 8'd1);
  assign err_next  = (err_count == 8'hFF) ? err_count : err_count + 8'd1;

  always_comb begin
    busy_sel  = 1'b0;
    start_vec = '0;
    for (int k = 0; k < NUM_DEV; k++) begin
      if (sel == 5'(k)) busy_sel = dev_busy[k];
      start_vec[k] = (sa == 5'(k + 1));
    end
  end

  // The mux stops sampling on the edge that leaves RUN so DONE never shows a stale word.
  assign run_exit = new_cmd | (seen & ~busy_sel) | timed_out;
  assign mux_en   = (state == ST_RUN) & ~run_exit;

  mkio_tx_mux #(.NUM_DEV(NUM_DEV)) u_tx_mux (
    .clk          (clk),
    .reset        (reset),
    .en           (mux_en),
    .bcast        (bcast),
    .sel          (sel),
    .dev_tx_data  (dev_tx_data),
    .dev_tx_cd    (dev_tx_cd),
    .dev_tx_ready (dev_tx_ready),
    .tx_data      (mux_data),
    .tx_cd        (mux_cd),
    .tx_ready     (mux_ready)
  );

  assign tx_data  = mux_data | own_data;
  assign tx_cd    = mux_cd;
  assign tx_ready = mux_ready | own_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      cmd_word    <= '0;
      pe_q        <= 1'b0;
      bcast       <= 1'b0;
      msg_err     <= 1'b0;
      seen        <= 1'b0;
      sel         <= '0;
      timer       <= '0;
      busy        <= 1'b0;
      dev_start   <= '0;
      err_timeout <= 1'b0;
      err_count   <= '0;
      own_data    <= '0;
      own_ready   <= 1'b0;
    end else begin
      dev_start   <= '0;
      err_timeout <= 1'b0;
      own_data    <= '0;
      own_ready   <= 1'b0;
      if (new_cmd && state inside {ST_DECODE, ST_DISPATCH, ST_RUN, ST_OWN_RESP}) begin
        cmd_word <= rx_data;
        pe_q     <= p_error;
        state    <= ST_DECODE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (new_cmd) begin
              cmd_word <= rx_data;
              pe_q     <= p_error;
              busy     <= 1'b1;
              state    <= ST_DECODE;
            end
          end
          ST_DECODE: begin
            bcast <= (addr == BROADCAST_ADDR);
            if (pe_q) begin
              err_count <= err_next;
              state     <= ST_DONE;
            end else if (addr != RT_ADDRESS && addr != BROADCAST_ADDR) begin
              state <= ST_DONE;
            end else if (sa == MODE_SA_LO || sa == MODE_SA_HI) begin
              msg_err <= 1'b0;
              state   <= ST_OWN_RESP;
            end else if (int'(sa) <= NUM_DEV) begin
              sel       <= sa - 5'd1;
              dev_start <= start_vec;
              state     <= ST_DISPATCH;
            end else begin
              msg_err   <= 1'b1;
              err_count <= err_next;
              state     <= ST_OWN_RESP;
            end
          end
          ST_DISPATCH: begin
            timer <= '0;
            seen  <= 1'b0;
            state <= ST_RUN;
          end
          ST_RUN: begin
            if (busy_sel) seen <= 1'b1;
            if (seen && !busy_sel) begin
              state <= ST_DONE;
            end else if (timed_out) begin
              err_timeout <= 1'b1;
              state       <= ST_DONE;
            end else begin
              timer <= timer + 8'd1;
            end
          end
          ST_OWN_RESP: begin
            if (!tx_busy) begin
              own_data  <= status_word(RT_ADDRESS, msg_err);
              own_ready <= ~bcast;
              state     <= ST_DONE;
            end
          end
          ST_DONE: begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mkio_rt_ctrl.sv
// tb/tb_mkio_rt_ctrl.sv - self-checking bench for mkio_rt_ctrl
module tb_mkio_rt_ctrl;

  localparam int         NUM_DEV = 4;
  localparam logic [4:0] RT      = 5'd1;
  localparam logic [7:0] TMO     = 8'd200;
  localparam int K_DROP = 0, K_OWN = 1, K_DEV = 2;

  logic                  clk, reset;
  logic [15:0]           rx_data;
  logic                  rx_cd, rx_valid, p_error, tx_busy;
  logic [NUM_DEV-1:0]    dev_busy, dev_tx_cd, dev_tx_ready, dev_start;
  logic [16*NUM_DEV-1:0] dev_tx_data;
  logic [15:0]           cmd_word, tx_data;
  logic                  tx_cd, tx_ready, busy, err_timeout;
  logic [7:0]            err_count;

  int tests, fails;
  int model_err;

  typedef struct {
    int          kind;
    int          dev;
    logic [15:0] status;
    logic        bcast;
    logic        inc;
  } exp_t;

  mkio_rt_ctrl #(.RT_ADDRESS(RT), .NUM_DEV(NUM_DEV), .RESP_TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_cd(rx_cd), .rx_valid(rx_valid),
    .p_error(p_error), .tx_busy(tx_busy), .dev_busy(dev_busy), .dev_tx_data(dev_tx_data),
    .dev_tx_cd(dev_tx_cd), .dev_tx_ready(dev_tx_ready), .dev_start(dev_start),
    .cmd_word(cmd_word), .tx_data(tx_data), .tx_cd(tx_cd), .tx_ready(tx_ready),
    .busy(busy), .err_timeout(err_timeout), .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1, "watchdog expired");
  end

  // Reference behaviour of one command, straight from the decode rules.
  function automatic exp_t predict(input logic [15:0] w, input logic pe);
    exp_t e;
    int a, s;
    a = int'(w[15:11]);
    s = int'(w[9:5]);
    e.kind = K_DROP; e.dev = 0; e.status = 16'h0; e.inc = 1'b0;
    e.bcast = (a == 31);
    if (pe) e.inc = 1'b1;
    else if (a != int'(RT) && a != 31) e.kind = K_DROP;
    else if (s == 0 || s == 31) begin
      e.kind = K_OWN; e.status = {RT, 1'b0, 10'd0};
    end else if (s <= NUM_DEV) begin
      e.kind = K_DEV; e.dev = s - 1;
    end else begin
      e.kind = K_OWN; e.status = {RT, 1'b1, 10'd0}; e.inc = 1'b1;
    end
    return e;
  endfunction

  task automatic send(input logic [15:0] w, input logic pe);
    rx_data = w; rx_cd = 1'b1; p_error = pe; rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0; rx_cd = 1'b0; p_error = 1'b0; rx_data = 16'($urandom);
  endtask

  task automatic clear_dev;
    dev_busy = '0; dev_tx_ready = '0; dev_tx_cd = '0; dev_tx_data = '0;
  endtask

  task automatic test_reset;
    reset = 1'b0; rx_valid = 1'b0; rx_cd = 1'b0; p_error = 1'b0; rx_data = '0; tx_busy = 1'b0;
    clear_dev();
    repeat (2) @(negedge clk);
    tests++; if (dev_start !== 4'b0)     begin fails++; $display("FAIL reset_dev_start got %b exp 0", dev_start); end
    tests++; if (cmd_word !== 16'h0)     begin fails++; $display("FAIL reset_cmd_word got %h exp 0", cmd_word); end
    tests++; if (tx_data !== 16'h0)      begin fails++; $display("FAIL reset_tx_data got %h exp 0", tx_data); end
    tests++; if (tx_cd !== 1'b0)         begin fails++; $display("FAIL reset_tx_cd got %b exp 0", tx_cd); end
    tests++; if (tx_ready !== 1'b0)      begin fails++; $display("FAIL reset_tx_ready got %b exp 0", tx_ready); end
    tests++; if (busy !== 1'b0)          begin fails++; $display("FAIL reset_busy got %b exp 0", busy); end
    tests++; if (err_timeout !== 1'b0)   begin fails++; $display("FAIL reset_err_timeout got %b exp 0", err_timeout); end
    tests++; if (err_count !== 8'd0)     begin fails++; $display("FAIL reset_err_count got %0d exp 0", err_count); end
    reset = 1'b1;
    model_err = 0;
    @(negedge clk);
    // A data-sync word in IDLE must not start anything.
    rx_data = 16'h0824; rx_cd = 1'b0; rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL data_word_ignored busy got %b exp 0", busy); end
  endtask

  task automatic test_dispatch;
    send(16'h0824, 1'b0);
    tests++; if (cmd_word !== 16'h0824) begin fails++; $display("FAIL disp_cmd_word got %h exp 0824", cmd_word); end
    tests++; if (busy !== 1'b1)         begin fails++; $display("FAIL disp_busy got %b exp 1", busy); end
    @(negedge clk);
    tests++; if (dev_start !== 4'b0001) begin fails++; $display("FAIL disp_start got %b exp 0001", dev_start); end
    @(negedge clk);
    tests++; if (dev_start !== 4'b0000) begin fails++; $display("FAIL disp_start_width got %b exp 0000", dev_start); end
    dev_busy[0] = 1'b1; dev_tx_ready[0] = 1'b1; dev_tx_cd[0] = 1'b1; dev_tx_data[15:0] = 16'h1234;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      tests++; if (tx_data !== 16'h1234 || tx_ready !== 1'b1 || tx_cd !== 1'b1)
        begin fails++; $display("FAIL disp_tx cyc%0d got %h/%b/%b exp 1234/1/1", i, tx_data, tx_ready, tx_cd); end
      if (i == 5) clear_dev();
    end
    @(negedge clk);
    tests++; if (tx_ready !== 1'b0) begin fails++; $display("FAIL disp_done_ready got %b exp 0", tx_ready); end
    @(negedge clk);
    tests++; if (busy !== 1'b0)     begin fails++; $display("FAIL disp_done_busy got %b exp 0", busy); end
  endtask

  task automatic test_bad_sa;
    send(16'h08E0, 1'b0);
    model_err++;
    @(negedge clk);
    tests++; if (dev_start !== 4'b0) begin fails++; $display("FAIL badsa_start got %b exp 0", dev_start); end
    @(negedge clk);
    tests++; if (tx_ready !== 1'b1 || tx_data !== 16'h0C00 || tx_cd !== 1'b0)
      begin fails++; $display("FAIL badsa_status got %h/%b/%b exp 0c00/1/0", tx_data, tx_ready, tx_cd); end
    tests++; if (err_count !== 8'(model_err)) begin fails++; $display("FAIL badsa_errcnt got %0d exp %0d", err_count, model_err); end
    @(negedge clk);
    tests++; if (tx_ready !== 1'b0 || busy !== 1'b0)
      begin fails++; $display("FAIL badsa_done got ready=%b busy=%b exp 0/0", tx_ready, busy); end
  endtask

  task automatic test_broadcast;
    send(16'hF840, 1'b0);
    @(negedge clk);
    tests++; if (dev_start !== 4'b0010) begin fails++; $display("FAIL bcast_start got %b exp 0010", dev_start); end
    @(negedge clk);
    dev_busy[1] = 1'b1; dev_tx_ready[1] = 1'b1; dev_tx_data[31:16] = 16'h5A5A;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      tests++; if (tx_ready !== 1'b0 || tx_data !== 16'h5A5A)
        begin fails++; $display("FAIL bcast_tx cyc%0d got %h/%b exp 5a5a/0", i, tx_data, tx_ready); end
      if (i == 4) clear_dev();
    end
    repeat (2) @(negedge clk);
    tests++; if (busy !== 1'b0 || tx_ready !== 1'b0)
      begin fails++; $display("FAIL bcast_done got busy=%b ready=%b exp 0/0", busy, tx_ready); end
  endtask

  task automatic test_timeout;
    int n;
    send(16'h0860, 1'b0);
    @(negedge clk);
    tests++; if (dev_start !== 4'b0100) begin fails++; $display("FAIL tmo_start got %b exp 0100", dev_start); end
    n = -1;
    for (int i = 1; i <= 400; i++) begin
      @(negedge clk);
      if (err_timeout === 1'b1) begin n = i; break; end
    end
    // Counted from the end of the dev_start cycle, the pulse lands RESP_TIMEOUT edges later.
    tests++; if (n != int'(TMO) + 1) begin fails++; $display("FAIL tmo_latency got %0d exp %0d", n, int'(TMO) + 1); end
    @(negedge clk);
    tests++; if (err_timeout !== 1'b0 || busy !== 1'b0)
      begin fails++; $display("FAIL tmo_after got pulse=%b busy=%b exp 0/0", err_timeout, busy); end
  endtask

  task automatic test_supersede;
    bit done;
    send(16'h1020, 1'b0);
    @(negedge clk);
    tests++; if (dev_start !== 4'b0) begin fails++; $display("FAIL other_addr_start got %b exp 0", dev_start); end
    @(negedge clk);
    tests++; if (busy !== 1'b0 || err_count !== 8'(model_err))
      begin fails++; $display("FAIL other_addr_idle got busy=%b cnt=%0d exp 0/%0d", busy, err_count, model_err); end
    send(16'h0840, 1'b0);
    @(negedge clk);
    tests++; if (dev_start !== 4'b0010) begin fails++; $display("FAIL sup_first_start got %b exp 0010", dev_start); end
    @(negedge clk);
    dev_busy[1] = 1'b1; dev_tx_ready[1] = 1'b1; dev_tx_data[31:16] = 16'hAAAA;
    @(negedge clk);
    tests++; if (tx_ready !== 1'b1 || tx_data !== 16'hAAAA)
      begin fails++; $display("FAIL sup_dev1_tx got %h/%b exp aaaa/1", tx_data, tx_ready); end
    send(16'h0824, 1'b0);
    tests++; if (cmd_word !== 16'h0824 || tx_ready !== 1'b0)
      begin fails++; $display("FAIL sup_relatch got %h/%b exp 0824/0", cmd_word, tx_ready); end
    @(negedge clk);
    tests++; if (dev_start !== 4'b0001) begin fails++; $display("FAIL sup_second_start got %b exp 0001", dev_start); end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      tests++; if (tx_ready !== 1'b0) begin fails++; $display("FAIL sup_dev1_masked cyc%0d got %b exp 0", i, tx_ready); end
    end
    dev_busy[0] = 1'b1;
    @(negedge clk);
    clear_dev();
    done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (busy === 1'b0) begin done = 1'b1; break; end
    end
    tests++; if (!done) begin fails++; $display("FAIL sup_finish got busy=%b exp 0 within 10 cycles", busy); end
  endtask

  task automatic test_random;
    exp_t e;
    logic [15:0] w;
    logic [4:0] a, s;
    logic pe, act;
    logic [NUM_DEV-1:0] exp_start;
    logic [15:0] pd, nd;
    logic pc, pr, nc, nr;
    int st, lat, blen, r;
    for (int it = 0; it < 40; it++) begin
      r = $urandom_range(0, 3);
      a = (r == 0) ? RT : (r == 1) ? 5'd31 : 5'($urandom_range(0, 31));
      s = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 1) == 1) s = 5'($urandom_range(1, NUM_DEV));
      pe = ($urandom_range(0, 7) == 0);
      w = {a, 1'($urandom), s, 5'($urandom)};
      e = predict(w, pe);
      if (e.inc && model_err < 255) model_err++;
      send(w, pe);
      tests++; if (cmd_word !== w || busy !== 1'b1)
        begin fails++; $display("FAIL rnd%0d_latch got %h/%b exp %h/1", it, cmd_word, busy, w); end
      @(negedge clk);
      exp_start = '0;
      if (e.kind == K_DEV) exp_start[e.dev] = 1'b1;
      tests++; if (dev_start !== exp_start)
        begin fails++; $display("FAIL rnd%0d_start got %b exp %b", it, dev_start, exp_start); end
      if (e.kind == K_DROP) begin
        @(negedge clk);
        tests++; if (busy !== 1'b0 || tx_ready !== 1'b0 || err_count !== 8'(model_err))
          begin fails++; $display("FAIL rnd%0d_drop got busy=%b rdy=%b cnt=%0d exp 0/0/%0d", it, busy, tx_ready, err_count, model_err); end
      end else if (e.kind == K_OWN) begin
        st = $urandom_range(0, 3);
        tx_busy = (st > 0);
        for (int i = 0; i < st; i++) begin
          @(negedge clk);
          tests++; if (tx_ready !== 1'b0) begin fails++; $display("FAIL rnd%0d_stall%0d got %b exp 0", it, i, tx_ready); end
          if (i == st - 1) tx_busy = 1'b0;
        end
        @(negedge clk);
        tests++; if (tx_ready !== ~e.bcast || tx_data !== e.status || tx_cd !== 1'b0 || err_count !== 8'(model_err))
          begin fails++; $display("FAIL rnd%0d_own got %h/%b/%b cnt=%0d exp %h/%b/0 cnt=%0d", it, tx_data, tx_ready, tx_cd, err_count, e.status, ~e.bcast, model_err); end
        @(negedge clk);
        tests++; if (tx_ready !== 1'b0 || busy !== 1'b0)
          begin fails++; $display("FAIL rnd%0d_own_done got rdy=%b busy=%b exp 0/0", it, tx_ready, busy); end
      end else begin
        lat = $urandom_range(0, 3);
        blen = $urandom_range(1, 4);
        pd = '0; pc = 1'b0; pr = 1'b0;
        for (int c = 0; c <= lat + blen + 1; c++) begin
          @(negedge clk);
          tests++; if (tx_data !== pd || tx_cd !== pc || tx_ready !== pr)
            begin fails++; $display("FAIL rnd%0d_run%0d got %h/%b/%b exp %h/%b/%b", it, c, tx_data, tx_cd, tx_ready, pd, pc, pr); end
          act = (c >= lat) && (c < lat + blen);
          nd = '0; nc = 1'b0; nr = 1'b0;
          for (int k = 0; k < NUM_DEV; k++) begin
            if (k == e.dev) begin
              nd = act ? 16'($urandom) : 16'h0;
              nc = act ? 1'($urandom) : 1'b0;
              nr = act ? 1'($urandom) : 1'b0;
              dev_busy[k] = act; dev_tx_data[16*k +: 16] = nd; dev_tx_cd[k] = nc; dev_tx_ready[k] = nr;
            end else begin
              dev_busy[k] = 1'($urandom); dev_tx_data[16*k +: 16] = 16'($urandom);
              dev_tx_cd[k] = 1'($urandom); dev_tx_ready[k] = 1'($urandom);
            end
          end
          pd = nd; pc = nc; pr = nr & ~e.bcast;
        end
        clear_dev();
        @(negedge clk);
        tests++; if (busy !== 1'b0 || tx_ready !== 1'b0)
          begin fails++; $display("FAIL rnd%0d_dev_done got busy=%b rdy=%b exp 0/0", it, busy, tx_ready); end
      end
    end
  endtask

  task automatic test_parity;
    logic [15:0] w;
    for (int it = 0; it < 300; it++) begin
      w = 16'($urandom);
      send(w, 1'b1);
      if (model_err < 255) model_err++;
      @(negedge clk);
      tests++; if (dev_start !== 4'b0 || tx_ready !== 1'b0)
        begin fails++; $display("FAIL pe%0d_quiet got start=%b rdy=%b exp 0/0", it, dev_start, tx_ready); end
      @(negedge clk);
      tests++; if (busy !== 1'b0 || tx_ready !== 1'b0)
        begin fails++; $display("FAIL pe%0d_idle got busy=%b rdy=%b exp 0/0", it, busy, tx_ready); end
      if (it == 0) begin
        tests++; if (err_count !== 8'(model_err)) begin fails++; $display("FAIL pe_first_cnt got %0d exp %0d", err_count, model_err); end
      end
    end
    tests++; if (err_count !== 8'd255) begin fails++; $display("FAIL pe_saturate got %0d exp 255", err_count); end
  endtask

  task automatic test_reset_mid_run;
    send(16'h0824, 1'b0);
    @(negedge clk);
    tests++; if (dev_start !== 4'b0001) begin fails++; $display("FAIL rst_run_start got %b exp 0001", dev_start); end
    @(negedge clk);
    dev_busy[0] = 1'b1; dev_tx_ready[0] = 1'b1; dev_tx_data[15:0] = 16'hBEEF;
    @(negedge clk);
    tests++; if (tx_ready !== 1'b1 || tx_data !== 16'hBEEF)
      begin fails++; $display("FAIL rst_run_tx got %h/%b exp beef/1", tx_data, tx_ready); end
    reset = 1'b0;
    #1;
    tests++; if (tx_ready !== 1'b0 || tx_data !== 16'h0 || busy !== 1'b0 || dev_start !== 4'b0 ||
                 err_count !== 8'd0 || cmd_word !== 16'h0 || err_timeout !== 1'b0 || tx_cd !== 1'b0)
      begin fails++; $display("FAIL rst_async got rdy=%b data=%h busy=%b cnt=%0d cmd=%h exp all 0", tx_ready, tx_data, busy, err_count, cmd_word); end
    clear_dev();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_release_busy got %b exp 0", busy); end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    model_err = 0;
    test_reset();
    test_dispatch();
    test_bad_sa();
    test_broadcast();
    test_timeout();
    test_supersede();
    test_random();
    test_parity();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
